// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator sequencer: one 3:2 carry-save step per accepted operand,
// then a single carry-propagate resolve cycle per packet before handing off the result.
module csa_accum_ctrl #(
    parameter int W       = 4,
    parameter int ACC_W   = 10,
    parameter int MAX_OPS = 2**(ACC_W-W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [ACC_W-W:0]     out_count,
    output logic                 out_trunc
);
    localparam int CW = ACC_W - W + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);
    localparam bit ONE_OP = (MAX_OPS == 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] s_q, c_q;
    logic [CW-1:0]    count_q;
    logic             trunc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CW-1:0]    out_count_q;
    logic             out_trunc_q;

    logic [ACC_W-1:0] x_d, csa_s_d, csa_c_d;
    logic [CW-1:0]    cnt_d;
    logic             accept;

    // The 3:2 step keeps the running total as redundant sum/carry vectors.
    assign x_d     = ACC_W'(in_data);
    assign csa_s_d = s_q ^ c_q ^ x_d;
    assign csa_c_d = ((s_q & c_q) | (s_q & x_d) | (c_q & x_d)) << 1;
    assign cnt_d   = count_q + 1'b1;
    assign accept  = in_valid && in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    s_q     <= x_d;
                    c_q     <= '0;
                    count_q <= CW'(1);
                    if (in_last || ONE_OP) begin
                        trunc_q    <= !in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= RESOLVE;
                    end else begin
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: if (accept) begin
                    s_q     <= csa_s_d;
                    c_q     <= csa_c_d;
                    count_q <= cnt_d;
                    if (in_last || cnt_d == MAX_CNT) begin
                        trunc_q    <= !in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    // Exact: MAX_OPS bounds the true sum below 2**ACC_W.
                    out_sum_q   <= s_q + c_q;
                    out_count_q <= count_q;
                    out_trunc_q <= trunc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    s_q         <= '0;
                    c_q         <= '0;
                    count_q     <= '0;
                    trunc_q     <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: hand-computed packet sums, latency, backpressure,
// truncation, bubbles, exhaustive 3-operand CSA sweep and asynchronous reset.
module tb_csa_accum_ctrl;
    localparam int W = 4;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_last;
    logic [W-1:0]     in_data;
    logic             out_valid, out_ready, out_trunc;
    logic [ACC_W-1:0] out_sum;
    logic [ACC_W-W:0] out_count;

    int n_cmp = 0;
    int n_err = 0;

    csa_accum_ctrl #(.W(W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand and returns 1 time unit after the edge that took it.
    task automatic send_op(input logic [W-1:0] d, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL send_op_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        n_cmp++;
        if ({in_ready, out_valid, out_trunc} !== 3'b100 || out_sum !== '0 || out_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%0b vld=%0b sum=%0d cnt=%0d tr=%0b required 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_count, out_trunc);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_op(4'd15, 1'b0);
        send_op(4'd15, 1'b0);
        send_op(4'd15, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_resolve: rdy=%0b vld=%0b required 0 0", in_ready, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 10'd45 || out_count !== 7'd3 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: vld=%0b rdy=%0b sum=%0d cnt=%0d tr=%0b required 1 0 45 3 0",
                     out_valid, in_ready, out_sum, out_count, out_trunc);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send_op(4'd7, 1'b1);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 10'd7 || out_count !== 7'd1 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL single_result: vld=%0b sum=%0d cnt=%0d tr=%0b required 1 7 1 0",
                     out_valid, out_sum, out_count, out_trunc);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd7 || out_count !== 7'd1) begin
            n_err++;
            $display("FAIL single_idle: vld=%0b rdy=%0b sum=%0d cnt=%0d required 0 1 7 1",
                     out_valid, in_ready, out_sum, out_count);
        end
    endtask

    task automatic test_trunc();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_op(4'd15, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL trunc_stop: rdy=%0b required 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 10'd960 || out_count !== 7'd64 || out_trunc !== 1'b1) begin
            n_err++;
            $display("FAIL trunc_result: vld=%0b sum=%0d cnt=%0d tr=%0b required 1 960 64 1",
                     out_valid, out_sum, out_count, out_trunc);
        end
        tick();
        send_op(4'd5, 1'b1);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 10'd5 || out_count !== 7'd1 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL trunc_next: vld=%0b sum=%0d cnt=%0d tr=%0b required 1 5 1 0",
                     out_valid, out_sum, out_count, out_trunc);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_op(4'd3, 1'b0);
        send_op(4'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_sum !== 10'd12 || out_count !== 7'd2 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: vld=%0b sum=%0d cnt=%0d rdy=%0b required 1 12 2 0",
                         i, out_valid, out_sum, out_count, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd12) begin
            n_err++;
            $display("FAIL bp_release: vld=%0b rdy=%0b sum=%0d required 0 1 12", out_valid, in_ready, out_sum);
        end
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        send_op(4'd1, 1'b0);
        tick(); tick();
        send_op(4'd2, 1'b0);
        tick();
        send_op(4'd4, 1'b1);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 10'd7 || out_count !== 7'd3 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL bubbles: vld=%0b sum=%0d cnt=%0d tr=%0b required 1 7 3 0",
                     out_valid, out_sum, out_count, out_trunc);
        end
        tick();
    endtask

    task automatic test_exhaustive();
        int bad = 0;
        out_ready = 1'b1;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < 16; z++) begin
                    send_op(W'(x), 1'b0);
                    send_op(W'(y), 1'b0);
                    send_op(W'(z), 1'b1);
                    tick();
                    n_cmp++;
                    if (out_valid !== 1'b1 || out_sum !== ACC_W'(x + y + z) || out_count !== 7'd3) begin
                        n_err++;
                        bad++;
                        if (bad <= 5)
                            $display("FAIL csa_triple(%0d,%0d,%0d): vld=%0b sum=%0d cnt=%0d required 1 %0d 3",
                                     x, y, z, out_valid, out_sum, out_count, x + y + z);
                    end
                    tick();
                end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_op(4'd1, 1'b0);
        send_op(4'd1, 1'b0);
        send_op(4'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_trunc} !== 3'b100 || out_sum !== '0 || out_count !== '0) begin
            n_err++;
            $display("FAIL reset_mid: rdy=%0b vld=%0b sum=%0d cnt=%0d tr=%0b required 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_count, out_trunc);
        end
        @(posedge clk); #1 rst = 1'b0;
        send_op(4'd1, 1'b0);
        send_op(4'd2, 1'b1);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 10'd3 || out_count !== 7'd2 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after: vld=%0b sum=%0d cnt=%0d tr=%0b required 1 3 2 0",
                     out_valid, out_sum, out_count, out_trunc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_trunc();
        test_backpressure();
        test_bubbles();
        test_exhaustive();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
